// File: rtl/cic_decim.sv
// Hogenauer CIC decimator: N_STAGES integrators at input rate, decimate by 2**RATE_LOG2,
// N_STAGES differential-delay-1 combs at output rate; output is the MSB slice.
module cic_decim #(
    parameter int unsigned I_WIDTH   = 16,
    parameter int unsigned O_WIDTH   = 16,
    parameter int unsigned N_STAGES  = 3,
    parameter int unsigned RATE_LOG2 = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic signed [I_WIDTH-1:0] data_i,
    output logic signed [O_WIDTH-1:0] data_o,
    output logic                      valid_o
);

    localparam int unsigned W_INT = I_WIDTH + N_STAGES * RATE_LOG2;
    localparam int unsigned CNT_W = (RATE_LOG2 > 0) ? RATE_LOG2 : 1;
    localparam int unsigned R     = 1 << RATE_LOG2;

    logic signed [W_INT-1:0] integ_q [N_STAGES];
    logic signed [W_INT-1:0] comb_q  [N_STAGES];
    logic signed [W_INT-1:0] dly_q   [N_STAGES];
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    cnt_last;
    logic                    dec_stb_q;
    logic                    comb_vld_q;
    logic signed [W_INT-1:0] data_ext;

    // Sign-extended input; wrap modulo 2**W_INT is intended throughout.
    assign data_ext = W_INT'(data_i);

    // With R=1 the counter degenerates: every accepted sample is a decimation point.
    always_comb begin
        cnt_d    = '0;
        cnt_last = 1'b1;
        if (RATE_LOG2 > 0) begin
            cnt_d    = cnt_q + CNT_W'(1);
            cnt_last = (cnt_q == CNT_W'(R - 1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q      <= '0;
            dec_stb_q  <= 1'b0;
            comb_vld_q <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
        end else begin
            if (en_i) begin
                integ_q[0] <= integ_q[0] + data_ext;
                for (int k = 1; k < N_STAGES; k++) begin
                    integ_q[k] <= integ_q[k] + integ_q[k-1];
                end
                cnt_q <= cnt_d;
            end
            dec_stb_q <= en_i && cnt_last;

            if (dec_stb_q) begin
                comb_q[0] <= integ_q[N_STAGES-1] - dly_q[0];
                dly_q[0]  <= integ_q[N_STAGES-1];
                for (int k = 1; k < N_STAGES; k++) begin
                    comb_q[k] <= comb_q[k-1] - dly_q[k];
                    dly_q[k]  <= comb_q[k-1];
                end
            end
            comb_vld_q <= dec_stb_q;

            valid_o <= comb_vld_q;
            if (comb_vld_q) begin
                data_o <= comb_q[N_STAGES-1][W_INT-1 -: O_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_cic_decim.sv
// Self-checking bench for cic_decim: bit-true model feeds a scoreboard queue of
// expected outputs and their arrival cycle; a negedge monitor checks data and timing.
module tb_cic_decim;

    localparam int unsigned IW = 16;
    localparam int unsigned OW = 16;
    localparam int unsigned NS = 3;
    localparam int unsigned RL = 4;
    localparam int unsigned RR = 1 << RL;
    localparam int unsigned W  = IW + NS * RL;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 en_i  = 1'b0;
    logic signed [IW-1:0] data_i = '0;
    logic signed [OW-1:0] data_o;
    logic                 valid_o;

    cic_decim #(
        .I_WIDTH  (IW),
        .O_WIDTH  (OW),
        .N_STAGES (NS),
        .RATE_LOG2(RL)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .data_i (data_i),
        .data_o (data_o),
        .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic signed [OW-1:0] val;
        int                   cyc;
    } exp_t;

    exp_t                q[$];
    int                  cyc = 0;
    int                  n_vec = 0;
    int                  n_err = 0;
    logic                armed = 1'b0;
    logic signed [OW-1:0] last_out = '0;

    logic signed [W-1:0] m_int  [NS];
    logic signed [W-1:0] m_comb [NS];
    logic signed [W-1:0] m_dly  [NS];
    int                  m_cnt;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NS; k++) begin
            m_int[k]  = '0;
            m_comb[k] = '0;
            m_dly[k]  = '0;
        end
        m_cnt = 0;
    endtask

    // Descending order keeps each stage reading its neighbour's pre-update value.
    task automatic model_accept(input logic signed [IW-1:0] d, input int edge_no);
        logic signed [W-1:0] in_v;
        exp_t e;
        for (int k = NS - 1; k > 0; k--) m_int[k] = m_int[k] + m_int[k-1];
        m_int[0] = m_int[0] + W'(d);
        if (m_cnt == RR - 1) begin
            m_cnt = 0;
            for (int k = NS - 1; k >= 0; k--) begin
                in_v      = (k == 0) ? m_int[NS-1] : m_comb[k-1];
                m_comb[k] = in_v - m_dly[k];
                m_dly[k]  = in_v;
            end
            e.val = m_comb[NS-1][W-1 -: OW];
            e.cyc = edge_no + 2;
            q.push_back(e);
        end else begin
            m_cnt++;
        end
    endtask

    task automatic drive(input logic en, input logic signed [IW-1:0] d);
        en_i   = en;
        data_i = d;
        @(posedge clk_i);
        #1;
        if (en) model_accept(d, cyc);
    endtask

    // Reset is applied with en_i high to show it takes priority.
    task automatic do_reset();
        rst_i  = 1'b1;
        en_i   = 1'b1;
        data_i = 16'sd1000;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        en_i  = 1'b0;
        model_clear();
        q.delete();
        last_out = '0;
        armed    = 1'b1;
        chk("reset_data_o", data_o, 0);
        chk("reset_valid_o", 32'(valid_o), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0);
    endtask

    always @(negedge clk_i) begin
        if (armed && !rst_i) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("valid_o_unexpected", 32'(valid_o), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data_o", data_o, e.val);
                    chk("valid_time", cyc, e.cyc);
                    last_out = e.val;
                end
            end else begin
                chk("data_o_hold", data_o, last_out);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("valid_o_missing", 32'(valid_o), 1);
                    last_out = q[0].val;
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int acc;
        model_clear();

        // DC input, continuous enable
        do_reset();
        for (int i = 0; i < 6 * RR; i++) drive(1'b1, 16'sd1000);
        idle(3);
        chk("dc_1000", data_o, 1000);

        // Full-scale negative DC: integrators overflow, output must not
        do_reset();
        for (int i = 0; i < 6 * RR; i++) drive(1'b1, -16'sd32768);
        idle(3);
        chk("dc_neg_full", data_o, -32768);

        // Alternating enable stretches the period only
        do_reset();
        for (int i = 0; i < 12 * RR; i++) drive(i[0] == 1'b0, 16'sd1000);
        idle(3);
        chk("dc_gapped", data_o, 1000);

        // Impulse response
        do_reset();
        drive(1'b1, 16'sd4096);
        for (int i = 1; i < 6 * RR; i++) drive(1'b1, '0);
        idle(3);
        chk("impulse_tail", data_o, 0);

        // Reset mid-stream at cnt=7 discards history
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 16'sd1000);
        do_reset();
        for (int i = 0; i < 6 * RR; i++) drive(1'b1, 16'sd1000);
        idle(3);
        chk("dc_after_reset", data_o, 1000);

        // Random data with random enable gaps
        do_reset();
        acc = 0;
        while (acc < 10000) begin
            logic en;
            en = ($urandom_range(0, 4) != 0);
            drive(en, IW'($urandom));
            if (en) acc++;
        end
        idle(3);
        chk("pending_outputs", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
